// File: rtl/bcd_seg_pkg.sv
// Shared definitions for the BCD 7-segment scanner: segment patterns,
// scan FSM state encoding and a constant clog2 helper for port widths.
package bcd_seg_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = segment lit.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Per-slot scan phase: anodes off first, then the digit is driven.
    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_e;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder; codes A-F show a dash.
module bcd_to_seg7
    import bcd_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Decode one BCD digit to its segment pattern.
    always_comb begin
        // NOTE: a default on every path keeps combinational logic free of inferred latches.
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan.sv
// Time-multiplexed common-anode 7-segment driver for packed BCD digits.
// Loads are staged in a pending register and copied to the displayed
// snapshot only at a frame boundary, so a frame never mixes two values.
// Optional leading-zero blanking: define BCD_SEG_LZB_EN.
module bcd_seg_scan
    import bcd_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 2,
    parameter int IDX_W      = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_done
);

    localparam int              PW        = clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END = PW'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    scan_state_e             state_q, state_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    fd_q, fd_d;

    logic                    wrap;
    logic                    boundary;
    logic [3:0]              cur_digit;
    logic [6:0]              dec_seg;
    logic                    blank_digit;

    // Decoder sees the digit of the slot being entered on the next edge.
    bcd_to_seg7 u_dec (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

`ifdef BCD_SEG_LZB_EN
    logic [NUM_DIGITS-1:0] lzb_mask;
    logic                  zero_run;

    // A digit above 0 is blanked when it and all more-significant digits are 0.
    always_comb begin
        lzb_mask = '0;
        zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run    = zero_run && (disp_q[4*k +: 4] == 4'd0);
            lzb_mask[k] = (k != 0) && zero_run;
        end
    end
`endif

    // Next-state logic for prescaler, slot index, snapshot, FSM and outputs.
    always_comb begin
        wrap     = (presc_q == PRESC_MAX);
        boundary = wrap && (idx_q == IDX_MAX);

        presc_d = wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (wrap) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

        // Last writer wins; a load on the boundary edge bypasses pending.
        pending_d  = load ? bcd_in : pending_q;
        pend_vld_d = load ? 1'b1 : pend_vld_q;
        disp_d     = disp_q;
        if (boundary) begin
            pend_vld_d = 1'b0;
            if (load)            disp_d = bcd_in;
            else if (pend_vld_q) disp_d = pending_q;
        end

        state_d = state_q;
        case (state_q)
            S_BLANK: if (presc_d == BLANK_END) state_d = S_DRIVE;
            S_DRIVE: if (wrap)                 state_d = S_BLANK;
            default: state_d = S_BLANK;
        endcase

        cur_digit = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) cur_digit = disp_q[4*k +: 4];
        end

`ifdef BCD_SEG_LZB_EN
        blank_digit = lzb_mask[idx_d];
`else
        blank_digit = 1'b0;
`endif

        an_d  = '0;
        seg_d = SEG_OFF;
        if (state_d == S_DRIVE) begin
            an_d[idx_d] = 1'b1;
            seg_d       = blank_digit ? SEG_OFF : dec_seg;
        end

        fd_d = boundary;
    end

    // State and registered outputs; reset blanks the display immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the snapshot registers are reset too, because the display must read 0 right after reset.
            pending_q  <= '0;
            pend_vld_q <= 1'b0;
            disp_q     <= '0;
            presc_q    <= '0;
            idx_q      <= '0;
            state_q    <= S_BLANK;
            an_q       <= '0;
            seg_q      <= SEG_OFF;
            fd_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            pending_q  <= pending_d;
            pend_vld_q <= pend_vld_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign digit_idx  = idx_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_bcd_seg_scan;

    logic        clk;
    logic        reset_n;
    logic        load;
    logic [15:0] bcd_in;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [1:0]  digit_idx;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef BCD_SEG_LZB_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    bcd_seg_scan #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load),
        .bcd_in     (bcd_in),
        .seg        (seg),
        .an         (an),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_fd, input logic [1:0] e_idx);
        n_tests++;
        assert ({an, seg, frame_done, digit_idx} === {e_an, e_seg, e_fd, e_idx}) else begin
            n_fail++;
            $error("FAIL %s: got an=%b seg=%h fd=%b idx=%0d, want an=%b seg=%h fd=%b idx=%0d",
                   tag, an, seg, frame_done, digit_idx, e_an, e_seg, e_fd, e_idx);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full slot: 2 blank cycles then 6 driven cycles; optional load at cycle load_at.
    task automatic check_slot(input string tag, input logic [1:0] idx, input logic [6:0] s,
                              input logic fd_first, input int load_at, input logic [15:0] val);
        for (int p = 0; p < 8; p++) begin
            check($sformatf("%s d%0d p%0d", tag, idx, p),
                  (p < 2) ? 4'b0000 : (4'b0001 << idx),
                  (p < 2) ? 7'h00 : s,
                  (p == 0) && fd_first, idx);
            if (p == load_at) begin
                load   = 1'b1;
                bcd_in = val;
            end
            tick();
            load = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3, input logic fd_first);
        check_slot(tag, 2'd0, s0, fd_first, -1, 16'h0);
        check_slot(tag, 2'd1, s1, 1'b0, -1, 16'h0);
        check_slot(tag, 2'd2, s2, 1'b0, -1, 16'h0);
        check_slot(tag, 2'd3, s3, 1'b0, -1, 16'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        bcd_in  = 16'h0000;

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            check("in_reset", 4'b0000, 7'h00, 1'b0, 2'd0);
        end
        reset_n = 1'b1;

        // Frame 0 shows zeros; 1234 is loaded in cycle 5 but must wait.
        check_slot("f0", 2'd0, 7'h3F, 1'b0, 5, 16'h1234);
        check_slot("f0", 2'd1, LZ, 1'b0, -1, 16'h0);
        check_slot("f0", 2'd2, LZ, 1'b0, -1, 16'h0);
        check_slot("f0", 2'd3, LZ, 1'b0, -1, 16'h0);

        // Frame 1 shows 1234.
        check_frame("f1", 7'h66, 7'h4F, 7'h5B, 7'h06, 1'b1);

        // Tear check: 9999 loaded in slot 1 must not appear this frame.
        check_slot("tear", 2'd0, 7'h66, 1'b1, -1, 16'h0);
        check_slot("tear", 2'd1, 7'h4F, 1'b0, 3, 16'h9999);
        check_slot("tear", 2'd2, 7'h5B, 1'b0, -1, 16'h0);
        check_slot("tear", 2'd3, 7'h06, 1'b0, -1, 16'h0);

        // 9999 frame; 5678 pended in slot 2, 0A01 loaded on the boundary edge.
        check_slot("f9", 2'd0, 7'h6F, 1'b1, -1, 16'h0);
        check_slot("f9", 2'd1, 7'h6F, 1'b0, -1, 16'h0);
        check_slot("f9", 2'd2, 7'h6F, 1'b0, 4, 16'h5678);
        check_slot("f9", 2'd3, 7'h6F, 1'b0, 7, 16'h0A01);

        // 0A01 shown on two consecutive frames; 5678 never appears.
        check_frame("bnd_a", 7'h06, 7'h3F, 7'h40, LZ, 1'b1);
        check_frame("bnd_b", 7'h06, 7'h3F, 7'h40, LZ, 1'b1);

        // Async reset in the middle of slot 2 drive phase.
        check_slot("pre_rst", 2'd0, 7'h06, 1'b1, -1, 16'h0);
        check_slot("pre_rst", 2'd1, 7'h3F, 1'b0, -1, 16'h0);
        for (int p = 0; p < 5; p++) begin
            check($sformatf("pre_rst d2 p%0d", p),
                  (p < 2) ? 4'b0000 : 4'b0100, (p < 2) ? 7'h00 : 7'h40, 1'b0, 2'd2);
            if (p < 4) tick();
        end
        #2 reset_n = 1'b0;
        #1 check("async_rst", 4'b0000, 7'h00, 1'b0, 2'd0);
        tick();
        check("async_hold", 4'b0000, 7'h00, 1'b0, 2'd0);
        reset_n = 1'b1;

        // After release the display restarts at slot 0 with disp = 0.
        check_frame("post_rst", 7'h3F, LZ, LZ, LZ, 1'b0);

`ifdef BCD_SEG_LZB_EN
        check_slot("lzb0", 2'd0, 7'h3F, 1'b1, 3, 16'h0007);
        check_slot("lzb0", 2'd1, 7'h00, 1'b0, -1, 16'h0);
        check_slot("lzb0", 2'd2, 7'h00, 1'b0, -1, 16'h0);
        check_slot("lzb0", 2'd3, 7'h00, 1'b0, -1, 16'h0);

        check_slot("lzb7", 2'd0, 7'h07, 1'b1, 3, 16'h0000);
        check_slot("lzb7", 2'd1, 7'h00, 1'b0, -1, 16'h0);
        check_slot("lzb7", 2'd2, 7'h00, 1'b0, -1, 16'h0);
        check_slot("lzb7", 2'd3, 7'h00, 1'b0, -1, 16'h0);

        check_slot("lzbz", 2'd0, 7'h3F, 1'b1, 3, 16'h0105);
        check_slot("lzbz", 2'd1, 7'h00, 1'b0, -1, 16'h0);
        check_slot("lzbz", 2'd2, 7'h00, 1'b0, -1, 16'h0);
        check_slot("lzbz", 2'd3, 7'h00, 1'b0, -1, 16'h0);

        check_frame("lzb105", 7'h6D, 7'h3F, 7'h06, 7'h00, 1'b1);
`else
        check_frame("post_rst2", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
